// File: rtl/banco_reg.sv
// 32 x 32-bit register file: one synchronous write port, two combinational read ports.
// R0 is hardwired to zero. Select bit [5] marks an out-of-range address.
module banco_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  sel,
  input  logic        RegWrite,
  input  logic [5:0]  selA,
  input  logic [5:0]  selB,
  input  logic [31:0] data,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2
);

  // R0 has no storage; its reads are forced to zero below.
  logic [31:0] regs [1:31];
  logic        write_en;

  assign write_en = RegWrite && !sel[5] && (sel[4:0] != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (write_en) begin
      regs[sel[4:0]] <= data;
    end
  end

  always_comb begin
    ReadData1 = '0;
    if (!selA[5] && (selA[4:0] != 5'd0)) begin
      ReadData1 = regs[selA[4:0]];
    end
  end

  always_comb begin
    ReadData2 = '0;
    if (!selB[5] && (selB[4:0] != 5'd0)) begin
      ReadData2 = regs[selB[4:0]];
    end
  end

endmodule

// File: tb/tb_banco_reg.sv
// Directed-vector bench for banco_reg with hand-computed expectations.
module tb_banco_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  sel;
  logic        RegWrite;
  logic [5:0]  selA;
  logic [5:0]  selB;
  logic [31:0] data;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;

  int vectors = 0;
  int errors  = 0;

  banco_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (sel),
    .RegWrite  (RegWrite),
    .selA      (selA),
    .selB      (selB),
    .data      (data),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2)
  );

  always #5 clk = ~clk;

  // Drive one write cycle: inputs set on the falling edge, held through the rising edge.
  task automatic do_write(input logic [5:0] s, input logic we, input logic [31:0] d);
    @(negedge clk);
    sel = s; RegWrite = we; data = d;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sel = '0; RegWrite = 1'b0; data = '0;
    selA = 6'd26; selB = 6'd22;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (ReadData1 !== 32'h0) begin
      errors++; $display("FAIL reset_hold_rd1 got %h expected %h", ReadData1, 32'h0);
    end
    vectors++;
    if (ReadData2 !== 32'h0) begin
      errors++; $display("FAIL reset_hold_rd2 got %h expected %h", ReadData2, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (ReadData1 !== 32'h0) begin
      errors++; $display("FAIL reset_rel_rd1 got %h expected %h", ReadData1, 32'h0);
    end
    vectors++;
    if (ReadData2 !== 32'h0) begin
      errors++; $display("FAIL reset_rel_rd2 got %h expected %h", ReadData2, 32'h0);
    end
  endtask

  task automatic test_basic_write;
    do_write(6'd18, 1'b1, 32'h99FF_FFFF);
    selA = 6'd18; selB = 6'd22;
    #1;
    vectors++;
    if (ReadData1 !== 32'h99FF_FFFF) begin
      errors++; $display("FAIL write_r18 got %h expected %h", ReadData1, 32'h99FF_FFFF);
    end
    selA = 6'd26;
    #1;
    vectors++;
    if (ReadData1 !== 32'h0) begin
      errors++; $display("FAIL untouched_r26 got %h expected %h", ReadData1, 32'h0);
    end
    vectors++;
    if (ReadData2 !== 32'h0) begin
      errors++; $display("FAIL untouched_r22 got %h expected %h", ReadData2, 32'h0);
    end
  endtask

  task automatic test_write_disabled;
    do_write(6'd22, 1'b0, 32'h1234_5678);
    selB = 6'd22;
    #1;
    vectors++;
    if (ReadData2 !== 32'h0) begin
      errors++; $display("FAIL we_low_r22 got %h expected %h", ReadData2, 32'h0);
    end
  endtask

  task automatic test_r0_out_of_range;
    do_write(6'd0, 1'b1, 32'hFFFF_FFFF);
    selA = 6'd0;
    #1;
    vectors++;
    if (ReadData1 !== 32'h0) begin
      errors++; $display("FAIL r0_write got %h expected %h", ReadData1, 32'h0);
    end
    do_write(6'b110010, 1'b1, 32'hA5A5_A5A5);
    selA = 6'd18;
    #1;
    vectors++;
    if (ReadData1 !== 32'h99FF_FFFF) begin
      errors++; $display("FAIL oor_write_r18 got %h expected %h", ReadData1, 32'h99FF_FFFF);
    end
    selA = 6'b110010;
    #1;
    vectors++;
    if (ReadData1 !== 32'h0) begin
      errors++; $display("FAIL oor_read got %h expected %h", ReadData1, 32'h0);
    end
  endtask

  task automatic test_read_during_write;
    do_write(6'd5, 1'b1, 32'h1);
    @(negedge clk);
    sel = 6'd5; RegWrite = 1'b1; data = 32'h2; selA = 6'd5; selB = 6'd5;
    #1;
    vectors++;
    if (ReadData1 !== 32'h1) begin
      errors++; $display("FAIL rdw_before_rd1 got %h expected %h", ReadData1, 32'h1);
    end
    vectors++;
    if (ReadData2 !== 32'h1) begin
      errors++; $display("FAIL rdw_before_rd2 got %h expected %h", ReadData2, 32'h1);
    end
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    vectors++;
    if (ReadData1 !== 32'h2) begin
      errors++; $display("FAIL rdw_after_rd1 got %h expected %h", ReadData1, 32'h2);
    end
    vectors++;
    if (ReadData2 !== 32'h2) begin
      errors++; $display("FAIL rdw_after_rd2 got %h expected %h", ReadData2, 32'h2);
    end
  endtask

  task automatic test_back_to_back;
    do_write(6'd31, 1'b1, 32'h8000_0001);
    do_write(6'd1,  1'b1, 32'h7FFF_FFFE);
    selA = 6'd31; selB = 6'd1;
    #1;
    vectors++;
    if (ReadData1 !== 32'h8000_0001) begin
      errors++; $display("FAIL b2b_r31 got %h expected %h", ReadData1, 32'h8000_0001);
    end
    vectors++;
    if (ReadData2 !== 32'h7FFF_FFFE) begin
      errors++; $display("FAIL b2b_r1 got %h expected %h", ReadData2, 32'h7FFF_FFFE);
    end
    selA = 6'd18; selB = 6'd5;
    #1;
    vectors++;
    if (ReadData1 !== 32'h99FF_FFFF) begin
      errors++; $display("FAIL b2b_keep_r18 got %h expected %h", ReadData1, 32'h99FF_FFFF);
    end
    vectors++;
    if (ReadData2 !== 32'h2) begin
      errors++; $display("FAIL b2b_keep_r5 got %h expected %h", ReadData2, 32'h2);
    end
    selA = 6'd30; selB = 6'b111111;
    #1;
    vectors++;
    if (ReadData1 !== 32'h0) begin
      errors++; $display("FAIL b2b_r30_zero got %h expected %h", ReadData1, 32'h0);
    end
    vectors++;
    if (ReadData2 !== 32'h0) begin
      errors++; $display("FAIL b2b_oor63 got %h expected %h", ReadData2, 32'h0);
    end
  endtask

  task automatic test_reset_mid;
    selA = 6'd18; selB = 6'd31;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (ReadData1 !== 32'h0) begin
      errors++; $display("FAIL midrst_r18 got %h expected %h", ReadData1, 32'h0);
    end
    vectors++;
    if (ReadData2 !== 32'h0) begin
      errors++; $display("FAIL midrst_r31 got %h expected %h", ReadData2, 32'h0);
    end
    // Attempt a write while reset is held; it must be blocked.
    sel = 6'd7; RegWrite = 1'b1; data = 32'hCAFE_F00D; selA = 6'd7;
    @(posedge clk);
    #1;
    vectors++;
    if (ReadData1 !== 32'h0) begin
      errors++; $display("FAIL write_in_reset got %h expected %h", ReadData1, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (ReadData1 !== 32'h0) begin
      errors++; $display("FAIL pre_first_edge got %h expected %h", ReadData1, 32'h0);
    end
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    vectors++;
    if (ReadData1 !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL first_edge_write got %h expected %h", ReadData1, 32'hCAFE_F00D);
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_write_disabled();
    test_r0_out_of_range();
    test_read_during_write();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule
